mio_bus_ctrl: RTL and testbench
===============================

// Module: mio_bus_ctrl
// PURPOSE
//  Parametrised, registered memory-mapped I/O bus controller between CPU and N_SLV slaves (RAM, VRAM, 7-seg, GPIO/counter, ...).
//  Decodes the address tag, drives one one-hot slave select and waits for that slave's ready, with timeout.
//  Registers read data and returns a one-cycle ack/err handshake to the CPU.
//  Successor to the combinational MIO decoder: adds wait states, timeout, error reporting and a parametrised slave map.
// PARAMETERS
//  N_SLV    4         number of slaves (1..8)
//  AW       32        address width
//  DW       32        data width
//  TAG_HI   31        MSB of address tag field
//  TAG_LO   28        LSB of address tag field; TW = TAG_HI-TAG_LO+1
//  SLV_TAG  16'hFED0  packed tags; slave i tag = SLV_TAG[i*TW +: TW] (default: s0=0, s1=D, s2=E, s3=F)
//  TIMEOUT  15        max ACCESS cycles without ready; 0 = timeout disabled
// PORTS
//  clk        in   1         system clock, all state on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  cpu_req    in   1         CPU transfer request; held until cpu_ack
//  cpu_we     in   1         1 = write, 0 = read
//  cpu_addr   in   AW        byte address
//  cpu_wdata  in   DW        write data
//  cpu_rdata  out  DW        registered read data
//  cpu_ack    out  1         one-cycle transfer-complete pulse
//  cpu_err    out  1         valid with cpu_ack: decode miss or timeout
//  err_addr   out  AW        address of most recent errored transfer (sticky)
//  slv_sel    out  N_SLV     one-hot slave select, high for the whole access
//  slv_we     out  1         write strobe, qualified by slv_sel
//  slv_addr   out  AW        latched address
//  slv_wdata  out  DW        latched write data
//  slv_rdata  in   N_SLV*DW  slave i read data at [i*DW +: DW]
//  slv_rdy    in   N_SLV     slave i ready/complete
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0, incl. cpu_rdata, err_addr and slv_sel (slv_sel cleared immediately).
//  - FSM IDLE -> ACCESS -> RESP -> IDLE.
//    - IDLE: cpu_req sampled only here.
//      - On req: latch addr/we/wdata into slv_addr/slv_we/slv_wdata.
//      - Decode tag; hit -> ACCESS, miss -> RESP with err.
//    - ACCESS: slv_sel[i]=1; slv_we=latched we.
//      - slv_rdy[i]=1 -> RESP; on read, cpu_rdata <= slv_rdata[i].
//      - Wait counter increments each ACCESS cycle.
//      - TIMEOUT!=0 and count reaches TIMEOUT with no rdy -> RESP with err.
//    - RESP: cpu_ack=1 for exactly one cycle; cpu_err set if miss/timeout; slv_sel=0; -> IDLE.
//  - Latency: zero-wait slave (rdy high in first ACCESS cycle) gives req sampled at edge k, ack high in cycle k+2.
//    Each wait cycle adds 1. Throughput is at most 1 transfer per 3 cycles.
//  - Multiple tag matches: lowest slave index wins.
//  - slv_rdy from non-selected slaves is ignored; rdy asserted in IDLE/RESP is ignored.
//  - cpu_rdata: updated only on successful reads; unchanged on writes; 0 on errored reads.
//  - err_addr: updated on every error; otherwise held.
//  - Timeout and rdy in the same cycle: rdy wins, no error.
//  - cpu_req dropped before ack: protocol violation; transfer still completes and acks.
//  - Reset mid-access aborts with no ack.
// STRUCTURE
//  - Shared header mio_defs.vh: state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), default SLV_TAG, tag field bounds.
//  - Sub-module mio_addr_decode: combinational priority tag match; outputs one-hot sel[N_SLV] and hit.
//    Instantiated once; everything else lives in mio_bus_ctrl.
// TESTING
//  1. Default params, slave0 rdy tied 1; read 0x0000_0040, slv_rdata0=0x1234_5678
//     -> slv_sel=4'b0001 one cycle; ack 2 cycles after req; cpu_rdata=0x1234_5678, err=0.
//  2. Write 0xE000_0000 data 0xCAFE_F00D, slave2 rdy after 3 waits
//     -> slv_sel=4'b0100 for 4 cycles, slv_we=1, slv_wdata=0xCAFE_F00D; ack, err=0; cpu_rdata unchanged.
//  3. Read 0x5000_0000 (no tag match)
//     -> no slv_sel; ack+err in cycle k+1; err_addr=0x5000_0000; cpu_rdata=0.
//  4. Read 0xF000_0004, slave3 never ready, TIMEOUT=15
//     -> sel held 15 cycles then ack+err; err_addr=0xF000_0004.
//     Repeat with rdy on cycle 15 -> err=0.
//  5. rst_n low during ACCESS (cycle 2 of a wait)
//     -> slv_sel=0 and all outputs 0 immediately, no ack.
//     Next req after release completes normally.
//  6. SLV_TAG override with duplicate tags (slave1 and slave3 both F)
//     -> access to 0xF... selects slave1 only; slave3 rdy ignored.

Source files
------------

// File: rtl/mio_bus_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O bus controller:
// FSM state encoding, default tag map and counter sizing helper.
package mio_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        MIO_IDLE   = 2'd0,
        MIO_ACCESS = 2'd1,
        MIO_RESP   = 2'd2
    } mio_state_e;

    localparam int          MIO_TAG_HI      = 31;
    localparam int          MIO_TAG_LO      = 28;
    localparam logic [15:0] MIO_DEF_SLV_TAG = 16'hFED0;

    // Wait counter only has to reach TIMEOUT-1; keep at least one bit.
    function automatic int mio_cnt_w(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address-tag decoder: one-hot select of the lowest-indexed
// slave whose tag matches, plus a hit flag.
module mio_addr_decode #(
    parameter int                  N_SLV   = 4,
    parameter int                  TW      = 4,
    parameter logic [N_SLV*TW-1:0] SLV_TAG = '0
) (
    input  logic [TW-1:0]    tag_i,
    output logic [N_SLV-1:0] sel_o,
    output logic             hit_o
);

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        sel_o = '0;
        hit_o = 1'b0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (tag_i == SLV_TAG[i*TW +: TW]) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Registered MMIO bus controller: decodes the address tag, holds a one-hot
// slave select until ready or timeout, then returns a one-cycle ack/err.
module mio_bus_ctrl
    import mio_bus_ctrl_pkg::*;
#(
    parameter int N_SLV   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TAG_HI  = MIO_TAG_HI,
    parameter int TAG_LO  = MIO_TAG_LO,
    parameter logic [N_SLV*(TAG_HI-TAG_LO+1)-1:0] SLV_TAG = MIO_DEF_SLV_TAG,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_ack,
    output logic                cpu_err,
    output logic [AW-1:0]       err_addr,
    output logic [N_SLV-1:0]    slv_sel,
    output logic                slv_we,
    output logic [AW-1:0]       slv_addr,
    output logic [DW-1:0]       slv_wdata,
    input  logic [N_SLV*DW-1:0] slv_rdata,
    input  logic [N_SLV-1:0]    slv_rdy
);

    localparam int TW = TAG_HI - TAG_LO + 1;
    localparam int CW = mio_cnt_w(TIMEOUT);

    mio_state_e        state_q, state_d;
    logic [N_SLV-1:0]  sel_q, sel_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [AW-1:0]     err_addr_q, err_addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [N_SLV-1:0]  dec_sel;
    logic              dec_hit;
    logic [DW-1:0]     rd_mux;
    logic              rdy_sel;
    logic              timed_out;

    mio_addr_decode #(
        .N_SLV   (N_SLV),
        .TW      (TW),
        .SLV_TAG (SLV_TAG)
    ) u_decode (
        .tag_i (cpu_addr[TAG_HI:TAG_LO]),
        .sel_o (dec_sel),
        .hit_o (dec_hit)
    );

    // sel_q is one-hot, so an AND-OR mux picks the active slave's data.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | slv_rdata[i*DW +: DW];
            end
        end
    end

    assign rdy_sel   = |(slv_rdy & sel_q);
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
        cnt_d      = cnt_q;
        case (state_q)
            MIO_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    sel_d   = dec_sel;
                    cnt_d   = '0;
                    if (dec_hit) begin
                        state_d = MIO_ACCESS;
                        err_d   = 1'b0;
                    end else begin
                        state_d    = MIO_RESP;
                        err_d      = 1'b1;
                        err_addr_d = cpu_addr;
                        if (!cpu_we) rdata_d = '0;
                    end
                end
            end
            MIO_ACCESS: begin
                // Ready is checked first so it beats a coincident timeout.
                if (rdy_sel) begin
                    state_d = MIO_RESP;
                    err_d   = 1'b0;
                    if (!we_q) rdata_d = rd_mux;
                end else if (timed_out) begin
                    state_d    = MIO_RESP;
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                    if (!we_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MIO_RESP: begin
                state_d = MIO_IDLE;
            end
            default: begin
                state_d = MIO_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MIO_IDLE;
            sel_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            err_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cpu_ack   = (state_q == MIO_RESP);
    assign cpu_err   = (state_q == MIO_RESP) && err_q;
    assign cpu_rdata = rdata_q;
    assign err_addr  = err_addr_q;
    assign slv_sel   = (state_q == MIO_ACCESS) ? sel_q : '0;
    assign slv_we    = (state_q == MIO_ACCESS) && we_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: directed vector table, reset-abort
// sequence and randomized transfers against a transaction-level model.
module tb_mio_bus_ctrl;

    localparam int TO = 15;

    logic         clk;
    logic         rst_n;
    logic         req_a, req_b;
    logic         cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic [127:0] slv_rdata;
    logic [3:0]   slv_rdy;

    logic [31:0]  rdata_a, eaddr_a, saddr_a, swdata_a;
    logic         ack_a, err_a, swe_a;
    logic [3:0]   sel_a;
    logic [31:0]  rdata_b, eaddr_b, saddr_b, swdata_b;
    logic         ack_b, err_b, swe_b;
    logic [3:0]   sel_b;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mdl_rd [2];
    logic [31:0] mdl_ea [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mio_bus_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(req_a), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_a),
        .cpu_ack(ack_a), .cpu_err(err_a), .err_addr(eaddr_a),
        .slv_sel(sel_a), .slv_we(swe_a), .slv_addr(saddr_a),
        .slv_wdata(swdata_a), .slv_rdata(slv_rdata), .slv_rdy(slv_rdy)
    );

    // Duplicate-tag map: slaves 1 and 3 both answer tag F.
    mio_bus_ctrl #(.SLV_TAG(16'hFEF0)) u_dup (
        .clk(clk), .rst_n(rst_n), .cpu_req(req_b), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_b),
        .cpu_ack(ack_b), .cpu_err(err_b), .err_addr(eaddr_b),
        .slv_sel(sel_b), .slv_we(swe_b), .slv_addr(saddr_b),
        .slv_wdata(swdata_b), .slv_rdata(slv_rdata), .slv_rdy(slv_rdy)
    );

    typedef struct {
        bit          dup;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          waits;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int tag_of(input bit dup, input int i);
        int t [4];
        t[0] = 0;
        t[1] = dup ? 15 : 13;
        t[2] = 14;
        t[3] = 15;
        return t[i];
    endfunction

    task automatic chk_zero(input string name, input bit dup);
        chk({name, "_rdata"}, 64'(dup ? rdata_b : rdata_a), 64'd0);
        chk({name, "_ack"},   64'(dup ? {ack_b, err_b, swe_b} : {ack_a, err_a, swe_a}), 64'd0);
        chk({name, "_eaddr"}, 64'(dup ? eaddr_b : eaddr_a), 64'd0);
        chk({name, "_sel"},   64'(dup ? sel_b : sel_a), 64'd0);
        chk({name, "_bus"},   dup ? {saddr_b, swdata_b} : {saddr_a, swdata_a}, 64'd0);
    endtask

    // One complete transfer. waits = ACCESS cycles before the target raises rdy.
    task automatic xfer(input bit dup, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd, input int waits);
        int          tgt, acc, ack_c;
        bit          exp_err, got_err, sel_ok, bus_ok;
        logic [3:0]  tbit, noise, sel_exp, sel_act;
        logic [31:0] rd_tgt;

        tgt = -1;
        for (int i = 0; i < 4; i++)
            if (tgt < 0 && int'(addr[31:28]) == tag_of(dup, i)) tgt = i;
        tbit = (tgt >= 0) ? 4'(1 << tgt) : 4'b0000;

        if (tgt < 0) begin
            acc = 0;           exp_err = 1'b1;
        end else if (waits < TO) begin
            acc = waits + 1;   exp_err = 1'b0;
        end else begin
            acc = TO;          exp_err = 1'b1;
        end

        for (int i = 0; i < 4; i++) slv_rdata[i*32 +: 32] = $urandom;
        rd_tgt = rd;
        if (tgt >= 0) slv_rdata[tgt*32 +: 32] = rd_tgt;

        if (!we) mdl_rd[dup] = exp_err ? 32'd0 : rd_tgt;
        if (exp_err) mdl_ea[dup] = addr;

        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; slv_rdy = 4'b0000;
        if (dup) req_b = 1'b1; else req_a = 1'b1;

        ack_c = 0; got_err = 1'b0; sel_ok = 1'b1; bus_ok = 1'b1;
        for (int c = 1; c <= 60 && ack_c == 0; c++) begin
            @(posedge clk); #1;
            noise = 4'($urandom) & ~tbit;
            if (dup && tgt != 3) noise[3] = 1'b1;
            slv_rdy = noise | ((tgt >= 0 && c >= waits + 1) ? tbit : 4'b0000);
            sel_exp = (tgt >= 0 && c <= acc) ? tbit : 4'b0000;
            sel_act = dup ? sel_b : sel_a;
            if (sel_act !== sel_exp) sel_ok = 1'b0;
            if (c <= acc && ((dup ? swe_b : swe_a) !== we ||
                             (dup ? saddr_b : saddr_a) !== addr ||
                             (dup ? swdata_b : swdata_a) !== wdata)) bus_ok = 1'b0;
            if (dup ? ack_b : ack_a) begin
                ack_c   = c;
                got_err = dup ? err_b : err_a;
            end
        end

        if (ack_c == 0) begin
            n_vec++; n_bad++;
            $display("FAIL ack_wait: no ack within 60 cycles for addr %h", addr);
        end else begin
            chk("ack_latency", 64'(ack_c), 64'(acc + 1));
            chk("err", 64'(got_err), 64'(exp_err));
        end
        chk("sel_onehot", 64'(sel_ok), 64'd1);
        chk("bus_latch", 64'(bus_ok), 64'd1);
        chk("rdata", 64'(dup ? rdata_b : rdata_a), 64'(mdl_rd[dup]));
        chk("err_addr", 64'(dup ? eaddr_b : eaddr_a), 64'(mdl_ea[dup]));

        req_a = 1'b0; req_b = 1'b0; slv_rdy = 4'b0000;
        @(posedge clk); #1;
        chk("ack_pulse", 64'(dup ? {ack_b, sel_b} : {ack_a, sel_a}), 64'd0);
    endtask

    vec_t vt [12];
    bit   ack_seen;
    int   r;
    logic [3:0] tags_r [5];

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; slv_rdata = '0; slv_rdy = '0;
        mdl_rd[0] = '0; mdl_rd[1] = '0; mdl_ea[0] = '0; mdl_ea[1] = '0;

        vt[0]  = '{0, 0, 32'h0000_0040, 32'h0,         32'h1234_5678, 0};
        vt[1]  = '{0, 1, 32'hE000_0000, 32'hCAFE_F00D, 32'h0,         3};
        vt[2]  = '{0, 0, 32'h5000_0000, 32'h0,         32'h0,         0};
        vt[3]  = '{0, 0, 32'hF000_0004, 32'h0,         32'h0BAD_0BAD, 99};
        vt[4]  = '{0, 0, 32'hF000_0004, 32'h0,         32'h7777_0015, 14};
        vt[5]  = '{0, 1, 32'h5000_0010, 32'h1111_2222, 32'h0,         0};
        vt[6]  = '{0, 0, 32'hD000_0010, 32'h0,         32'h89AB_CDEF, 1};
        vt[7]  = '{0, 1, 32'hF000_0100, 32'h3333_4444, 32'h0,         40};
        vt[8]  = '{1, 0, 32'hF000_0000, 32'h0,         32'h5A5A_A5A5, 2};
        vt[9]  = '{1, 0, 32'hE000_0008, 32'h0,         32'h0F0F_0F0F, 0};
        vt[10] = '{1, 1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         5};
        vt[11] = '{1, 0, 32'hD000_0000, 32'h0,         32'h0,         0};

        #2;
        chk_zero("reset_a", 1'b0);
        chk_zero("reset_b", 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            xfer(vt[i].dup, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].waits);

        // Reset in the second wait cycle of an access must abort without ack.
        xfer(0, 1, 32'h6000_0000, 32'h0000_0001, 32'h0, 0);
        xfer(0, 0, 32'h0000_0100, 32'h0, 32'hA5A5_0001, 0);
        slv_rdy = 4'b0000; cpu_we = 1'b0; cpu_addr = 32'hF000_0008; req_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pre_sel", 64'(sel_a), 64'h8);
        rst_n = 1'b0;
        #1;
        chk_zero("abort", 1'b0);
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack_a) ack_seen = 1'b1;
        end
        chk("abort_no_ack", 64'(ack_seen), 64'd0);
        req_a = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mdl_rd[0] = '0; mdl_rd[1] = '0; mdl_ea[0] = '0; mdl_ea[1] = '0;
        xfer(0, 0, 32'hF000_0008, 32'h0, 32'h2468_ACE0, 2);

        tags_r[0] = 4'h0; tags_r[1] = 4'hD; tags_r[2] = 4'hE; tags_r[3] = 4'hF;
        tags_r[4] = 4'($urandom_range(1, 12));
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = $urandom;
            a[31:28] = tags_r[$urandom_range(0, 4)];
            r = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4);
            xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, $urandom, r);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
